// File: rtl/dmem_responder.sv
// Data-memory responder for the core's M-stage port.
// Serves word-addressed loads and byte-strobed stores from a local array after a
// fixed number of wait states, raising busy_m so the hazard unit holds the pipeline
// while an access is outstanding. WAIT_STATES=0 degenerates into a combinational
// read / edge-committed write with no stall.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_m,
  input  logic        req_write_m,
  input  logic [31:0] req_addr_m,
  input  logic [31:0] req_wdata_m,
  input  logic [3:0]  req_be_m,
  output logic [31:0] rdata_m,
  output logic        resp_valid_m,
  output logic        busy_m,
  output logic        misaligned_m
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Storage is deliberately not reset; software sees whatever was last written.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] req_idx_s;
  logic          req_mis_s;
  logic          addr_unused_s;

  assign req_idx_s     = req_addr_m[2 +: AW];
  assign req_mis_s     = (req_addr_m[1:0] != 2'b00);
  // Upper address bits only alias back onto the array.
  assign addr_unused_s = ^req_addr_m[31:AW+2];

  // Replace the strobed byte lanes of a word with the new store data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  generate
    if (WAIT_STATES == 0) begin : g_pass
      logic        mem_we_s;
      logic [31:0] rdata_s;

      // A valid aligned store in this cycle commits at the closing edge.
      always_comb begin
        mem_we_s = 1'b0;
        if (req_valid_m && req_write_m && !req_mis_s && reset) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end

      // Asynchronous read of the addressed word; misaligned addresses read as zero.
      always_comb begin
        rdata_s = 32'd0;
        if (req_mis_s) begin
          rdata_s = 32'd0;
        end else begin
          rdata_s = mem_q[req_idx_s];
        end
      end

      // Array write port.
      always_ff @(posedge clk) begin
        if (mem_we_s) begin
          mem_q[req_idx_s] <= merge_bytes(mem_q[req_idx_s], req_wdata_m, req_be_m);
        end
      end

      assign rdata_m      = rdata_s;
      assign resp_valid_m = req_valid_m;
      assign busy_m       = 1'b0;
      assign misaligned_m = req_valid_m & req_mis_s;

    end else begin : g_fsm
      typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
      } state_e;

      // cnt holds the busy cycles still owed, counting the current one.
      localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

      state_e        state_q, state_d;
      logic [3:0]    cnt_q, cnt_d;
      logic          lat_write_q, lat_write_d;
      logic [AW+1:0] lat_addr_q, lat_addr_d;
      logic [31:0]   lat_wdata_q, lat_wdata_d;
      logic [3:0]    lat_be_q, lat_be_d;
      logic [31:0]   rdata_q, rdata_d;
      logic          resp_valid_q, resp_valid_d;
      logic          misaligned_q, misaligned_d;
      logic          busy_s;

      // Effective request: live inputs while idle (single-wait case), latched copy otherwise.
      logic          src_write_s;
      logic [AW-1:0] src_idx_s;
      logic          src_mis_s;
      logic [31:0]   src_wdata_s;
      logic [3:0]    src_be_s;
      logic          mem_we_s;

      // Select which copy of the request feeds the completion edge.
      always_comb begin
        src_write_s = lat_write_q;
        src_idx_s   = lat_addr_q[AW+1:2];
        src_mis_s   = (lat_addr_q[1:0] != 2'b00);
        src_wdata_s = lat_wdata_q;
        src_be_s    = lat_be_q;
        if (state_q == S_IDLE) begin
          src_write_s = req_write_m;
          src_idx_s   = req_idx_s;
          src_mis_s   = req_mis_s;
          src_wdata_s = req_wdata_m;
          src_be_s    = req_be_m;
        end else begin
          src_write_s = lat_write_q;
        end
      end

      // Next-state, latch, completion and stall logic.
      always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        lat_be_d     = lat_be_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        misaligned_d = 1'b0;
        busy_s       = 1'b0;
        mem_we_s     = 1'b0;

        case (state_q)
          S_IDLE: begin
            busy_s = req_valid_m;
            if (req_valid_m) begin
              lat_write_d = req_write_m;
              lat_addr_d  = req_addr_m[AW+1:0];
              lat_wdata_d = req_wdata_m;
              lat_be_d    = req_be_m;
              cnt_d       = CNT_INIT;
              if (WAIT_STATES >= 2) begin
                state_d = S_WAIT;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              state_d = S_IDLE;
            end
          end
          S_WAIT: begin
            busy_s = 1'b1;
            if (cnt_q <= 4'd1) begin
              cnt_d   = 4'd0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          S_DONE: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end
          default: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end
        endcase

        // The edge entering DONE performs the array access and registers the response.
        if (state_d == S_DONE) begin
          resp_valid_d = 1'b1;
          misaligned_d = src_mis_s;
          if (src_mis_s) begin
            rdata_d = 32'd0;
          end else if (src_write_s) begin
            mem_we_s = reset;
          end else begin
            rdata_d = mem_q[src_idx_s];
          end
        end else begin
          resp_valid_d = 1'b0;
        end
      end

      // State and response registers; reset abandons any access in flight.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q      <= S_IDLE;
          cnt_q        <= 4'd0;
          lat_write_q  <= 1'b0;
          lat_addr_q   <= '0;
          lat_wdata_q  <= 32'd0;
          lat_be_q     <= 4'd0;
          rdata_q      <= 32'd0;
          resp_valid_q <= 1'b0;
          misaligned_q <= 1'b0;
        end else begin
          state_q      <= state_d;
          cnt_q        <= cnt_d;
          lat_write_q  <= lat_write_d;
          lat_addr_q   <= lat_addr_d;
          lat_wdata_q  <= lat_wdata_d;
          lat_be_q     <= lat_be_d;
          rdata_q      <= rdata_d;
          resp_valid_q <= resp_valid_d;
          misaligned_q <= misaligned_d;
        end
      end

      // Array write port.
      always_ff @(posedge clk) begin
        if (mem_we_s) begin
          mem_q[src_idx_s] <= merge_bytes(mem_q[src_idx_s], src_wdata_s, src_be_s);
        end
      end

      assign rdata_m      = rdata_q;
      assign resp_valid_m = resp_valid_q;
      assign busy_m       = busy_s;
      assign misaligned_m = misaligned_q;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 3 and 0 wait states) driven by
// directed accesses; a per-instance memory model predicts every output each cycle.
module tb_dmem_responder;

  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  valid_v, write_v, busy_v, resp_v, mis_v;
  logic [31:0] addr_v [3];
  logic [31:0] wdata_v [3];
  logic [31:0] rdata_v [3];
  logic [3:0]  be_v [3];

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(2)) u_n2 (
    .clk(clk), .reset(reset), .req_valid_m(valid_v[0]), .req_write_m(write_v[0]),
    .req_addr_m(addr_v[0]), .req_wdata_m(wdata_v[0]), .req_be_m(be_v[0]),
    .rdata_m(rdata_v[0]), .resp_valid_m(resp_v[0]), .busy_m(busy_v[0]), .misaligned_m(mis_v[0]));

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(3)) u_n3 (
    .clk(clk), .reset(reset), .req_valid_m(valid_v[1]), .req_write_m(write_v[1]),
    .req_addr_m(addr_v[1]), .req_wdata_m(wdata_v[1]), .req_be_m(be_v[1]),
    .rdata_m(rdata_v[1]), .resp_valid_m(resp_v[1]), .busy_m(busy_v[1]), .misaligned_m(mis_v[1]));

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) u_n0 (
    .clk(clk), .reset(reset), .req_valid_m(valid_v[2]), .req_write_m(write_v[2]),
    .req_addr_m(addr_v[2]), .req_wdata_m(wdata_v[2]), .req_be_m(be_v[2]),
    .rdata_m(rdata_v[2]), .resp_valid_m(resp_v[2]), .busy_m(busy_v[2]), .misaligned_m(mis_v[2]));

  int nws [3] = '{2, 3, 0};
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses1 = 0;

  // Model state: memory contents, which words were written, and expected outputs.
  logic [31:0] mdl [3][DW];
  bit          seen [3][DW];
  bit          exp_busy [3];
  bit          exp_resp [3];
  bit          exp_mis [3];
  bit          exp_rdv [3];
  logic [31:0] exp_rdata [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare every instance against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (resp_v[1] === 1'b1) pulses1++;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy[%0d] cyc %0d", k, cyc), {31'd0, busy_v[k]}, {31'd0, exp_busy[k]});
      check($sformatf("resp[%0d] cyc %0d", k, cyc), {31'd0, resp_v[k]}, {31'd0, exp_resp[k]});
      check($sformatf("mis[%0d] cyc %0d", k, cyc), {31'd0, mis_v[k]}, {31'd0, exp_mis[k]});
      if (exp_rdv[k]) begin
        check($sformatf("rdata[%0d] cyc %0d", k, cyc), rdata_v[k], exp_rdata[k]);
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input int k, input int idx, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
    end
    seen[k][idx] = 1'b1;
  endtask

  // One complete access on instance k; entered and left 1ns after a rising edge.
  task automatic acc(input int k, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    int n;
    bit mis;
    int idx;
    n   = nws[k];
    mis = (a[1:0] != 2'b00);
    idx = int'(a[9:2]);
    valid_v[k] = 1'b1;
    write_v[k] = wr;
    addr_v[k]  = a;
    wdata_v[k] = d;
    be_v[k]    = be;
    if (n == 0) begin
      exp_busy[k]  = 1'b0;
      exp_resp[k]  = 1'b1;
      exp_mis[k]   = mis;
      exp_rdv[k]   = mis || seen[k][idx];
      exp_rdata[k] = mis ? 32'd0 : mdl[k][idx];
      @(posedge clk);
      if (wr && !mis) commit(k, idx, d, be);
      #1;
    end else begin
      // N busy cycles, then one response cycle.
      exp_busy[k] = 1'b1;
      exp_resp[k] = 1'b0;
      exp_mis[k]  = 1'b0;
      go();
      for (int c = 1; c < n; c++) go();
      exp_busy[k] = 1'b0;
      exp_resp[k] = 1'b1;
      exp_mis[k]  = mis;
      if (mis) exp_rdata[k] = 32'd0;
      else if (!wr) exp_rdata[k] = mdl[k][idx];
      if (wr && !mis) commit(k, idx, d, be);
      go();
    end
    valid_v[k]  = 1'b0;
    exp_busy[k] = 1'b0;
    exp_resp[k] = 1'b0;
    exp_mis[k]  = 1'b0;
    if (n == 0) exp_rdv[k] = 1'b0;
  endtask

  initial begin
    int c0;
    int p0;
    reset   = 1'b0;
    valid_v = 3'b000;
    write_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr_v[k]    = 32'd0;
      wdata_v[k]   = 32'd0;
      be_v[k]      = 4'd0;
      exp_busy[k]  = 1'b0;
      exp_resp[k]  = 1'b0;
      exp_mis[k]   = 1'b0;
      exp_rdv[k]   = (k != 2);
      exp_rdata[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset rdata n2", rdata_v[0], 32'd0);
    check("reset rdata n3", rdata_v[1], 32'd0);
    check("reset busy/resp/mis", {29'd0, busy_v[0], resp_v[0], mis_v[0]}, 32'd0);
    reset = 1'b1;

    // Basic store then load, two wait states.
    acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    acc(0, 1'b0, 32'h10, 32'd0, 4'h0);
    check("load 0x10", rdata_v[0], 32'hDEADBEEF);

    // Byte strobes.
    acc(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    acc(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    acc(0, 1'b0, 32'h20, 32'd0, 4'h0);
    check("byte merge", rdata_v[0], 32'h11BB33DD);

    // Misaligned load and store.
    acc(0, 1'b0, 32'h13, 32'd0, 4'h0);
    check("misaligned load rdata", rdata_v[0], 32'd0);
    acc(0, 1'b1, 32'h21, 32'hFFFFFFFF, 4'hF);
    acc(0, 1'b0, 32'h20, 32'd0, 4'h0);
    check("misaligned store no write", rdata_v[0], 32'h11BB33DD);

    // Back-to-back on three wait states: load, load, store.
    acc(1, 1'b1, 32'h30, 32'hA5A50001, 4'hF);
    acc(1, 1'b1, 32'h34, 32'h5A5A0002, 4'hF);
    go();
    c0 = cyc;
    p0 = pulses1;
    acc(1, 1'b0, 32'h30, 32'd0, 4'h0);
    acc(1, 1'b0, 32'h34, 32'd0, 4'h0);
    acc(1, 1'b1, 32'h38, 32'h0BADCAFE, 4'hF);
    check("b2b cycles", c0 > 0 ? cyc - c0 : -1, 32'd12);
    check("b2b pulses", pulses1 - p0, 32'd3);
    check("rdata held over store", rdata_v[1], 32'h5A5A0002);

    // Reset during the wait of a store to 0x40.
    acc(0, 1'b1, 32'h40, 32'h12345678, 4'hF);
    valid_v[0]  = 1'b1;
    write_v[0]  = 1'b1;
    addr_v[0]   = 32'h40;
    wdata_v[0]  = 32'hCAFEF00D;
    be_v[0]     = 4'hF;
    exp_busy[0] = 1'b1;
    go();
    @(negedge clk);
    #1;
    reset   = 1'b0;
    valid_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      exp_busy[k]  = 1'b0;
      exp_resp[k]  = 1'b0;
      exp_mis[k]   = 1'b0;
      exp_rdata[k] = 32'd0;
    end
    exp_rdv[2] = 1'b0;
    #1;
    check("busy drops on reset", {31'd0, busy_v[0]}, 32'd0);
    go();
    reset = 1'b1;
    acc(0, 1'b0, 32'h40, 32'd0, 4'h0);
    check("aborted store not committed", rdata_v[0], 32'h12345678);

    // Pass-through mode with address aliasing.
    acc(2, 1'b1, 32'h400, 32'h5, 4'hF);
    acc(2, 1'b0, 32'h0, 32'd0, 4'h0);
    check("alias load 0x0", rdata_v[2], 32'h5);

    go();
    go();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
